// File: rtl/dmp_deserial.sv
`default_nettype none
// ============================================================================
// Module      : dmp_deserial
// Description : Receive side of the deterministic serial pagerank stream.
//               Collects one beat per hardware thread (thread order 0..N-1,
//               framed by start/end markers) into a registered buffer, then
//               presents every thread's vector with its own valid/ack pair.
// Ports       : clock, reset_n          - clock, async active-low reset
//               stream_valid/start/end  - beat qualifiers from the stream
//               stream_data             - one thread's pagerank vector
//               stream_ready            - beat accepted on valid & ready
//               page_rank_scatter       - reassembled buffer, all threads
//               scatter_valid/thread_ack- per-thread delivery handshake
//               busy                    - not idle
//               err, err_code           - only with DMP_DESERIAL_ERR_EN
// Option      : `define DMP_DESERIAL_ERR_EN adds sticky protocol-error ports
//               (err_code: 1 missing end, 2 early end, 3 start mid-packet).
// Revision    : 1.0 - initial release
// ============================================================================
module dmp_deserial #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  input  logic                                          stream_valid,
  input  logic                                          stream_start,
  input  logic                                          stream_end,
  input  logic [NODES_IN_GRAPH-1:0][63:0]               stream_data,
  output logic                                          stream_ready,
  output logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][63:0] page_rank_scatter,
  output logic [NUM_HW_THREADS-1:0]                     scatter_valid,
  input  logic [NUM_HW_THREADS-1:0]                     thread_ack,
`ifdef DMP_DESERIAL_ERR_EN
  output logic                                          err,
  output logic [1:0]                                    err_code,
`endif
  output logic                                          busy
);

  localparam int IDX_W = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(NUM_HW_THREADS - 1);
  localparam logic [NUM_HW_THREADS-1:0] ALL_VALID = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_HW_THREADS-1:0] valid_q, valid_d;
  logic                      wr_en;
  logic [IDX_W-1:0]          wr_slot;
  logic                      perr;
  logic [1:0]                perr_code;
  logic                      accept;

  assign stream_ready  = (state_q != DELIVER);
  assign busy          = (state_q != IDLE);
  assign scatter_valid = valid_q;
  assign accept        = stream_valid & stream_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    wr_en     = 1'b0;
    wr_slot   = idx_q;
    perr      = 1'b0;
    perr_code = 2'd0;
    case (state_q)
      IDLE: begin
        // Only a start beat opens a packet; stray beats are dropped.
        if (accept && stream_start) begin
          wr_en   = 1'b1;
          wr_slot = '0;
          if (stream_end || NUM_HW_THREADS == 1) begin
            state_d = DELIVER;
            valid_d = ALL_VALID;
            idx_d   = '0;
          end else begin
            state_d = RECV;
            idx_d   = IDX_W'(1);
          end
        end
      end
      RECV: begin
        if (accept) begin
          wr_en = 1'b1;
          if (stream_start) begin
            // Resync: the new start beat owns slot 0. With end on the same
            // beat the packet is too short and is abandoned.
            wr_slot = '0;
            perr    = 1'b1;
            if (stream_end) begin
              state_d   = IDLE;
              idx_d     = '0;
              perr_code = 2'd2;
            end else begin
              idx_d     = IDX_W'(1);
              perr_code = 2'd3;
            end
          end else if (idx_q == LAST_IDX) begin
            // Last slot filled: deliver even if the end marker is missing.
            state_d = DELIVER;
            valid_d = ALL_VALID;
            idx_d   = '0;
            if (!stream_end) begin
              perr      = 1'b1;
              perr_code = 2'd1;
            end
          end else if (stream_end) begin
            state_d   = IDLE;
            idx_d     = '0;
            perr      = 1'b1;
            perr_code = 2'd2;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DELIVER: begin
        // Acks on already-cleared bits are masked out naturally.
        valid_d = valid_q & ~thread_ack;
        if (valid_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Each slot only loads on an accepted beat addressed to it, so slots not
  // reached by an aborted packet keep the previous packet's data.
  for (genvar i = 0; i < NUM_HW_THREADS; i++) begin : g_slot
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        page_rank_scatter[i] <= '0;
      end else if (wr_en && (wr_slot == IDX_W'(i))) begin
        page_rank_scatter[i] <= stream_data;
      end
    end
  end

`ifdef DMP_DESERIAL_ERR_EN
  logic       err_q;
  logic [1:0] err_code_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else if (perr && !err_q) begin
      err_q      <= 1'b1;
      err_code_q <= perr_code;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
`else
  logic unused_err;
  assign unused_err = ^{perr, perr_code};
`endif

endmodule
`default_nettype wire

// File: doc/dmp_deserial.md
Name: dmp_deserial

Overview:
- Receive-side counterpart of the deterministic serial stream. Accepts one thread packet per beat, in thread order 0..NUM_HW_THREADS-1, framed by start and end markers.
- Reassembles the beats into a per-thread pagerank buffer and scatters each thread's vector back to that thread with a per-thread valid/ack handshake.
- Sits between the ordered serial stream and the per-partition apply/scatter stage of each hardware thread.

Parameters:
- NUM_HW_THREADS, 8: number of partitions, i.e. beats per packet (>=1).
- NODES_IN_GRAPH, 32: 64-bit pagerank words per beat.
- IDX_W, $clog2(NUM_HW_THREADS) clamped to >=1: thread index width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock; reset_n is asynchronous, active-low.
- reset_n  in  1  asynchronous active-low reset.
- stream_valid  in  1  beat present.
- stream_start  in  1  beat is thread 0 (first of packet).
- stream_end  in  1  beat is thread NUM_HW_THREADS-1 (last of packet).
- stream_data  in  64 x [NODES_IN_GRAPH]  pagerank vector of current thread.
- stream_ready  out  1  beat accepted when stream_valid & stream_ready.
- page_rank_scatter  out  64 x [NUM_HW_THREADS][NODES_IN_GRAPH]  reassembled buffer (registered).
- scatter_valid  out  [NUM_HW_THREADS]  thread i's vector available.
- thread_ack  in  [NUM_HW_THREADS]  thread i consumed its vector.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, thread_idx=0, all page_rank_scatter words=0, scatter_valid=0, busy=0, stream_ready=1 (combinational from IDLE).
- States:
  - IDLE: ready=1. A beat with start writes buf[0] and sets thread_idx=1 -> RECV. If that beat also has end, or NUM_HW_THREADS==1 -> DELIVER instead. Beats without start are dropped.
  - RECV: ready=1. Each accepted beat writes buf[thread_idx] and increments thread_idx. stream_valid low = stall, no timeout.
  - DELIVER: ready=0. scatter_valid = one bit per thread, all set on entry.
- End and restart handling in RECV:
  - Beat with end at thread_idx==NUM_HW_THREADS-1: write, then -> DELIVER.
  - Beat at thread_idx==NUM_HW_THREADS-1 without end: treated as complete, written, -> DELIVER, protocol error.
  - Beat with end at thread_idx<NUM_HW_THREADS-1: written, packet aborted, -> IDLE, no delivery, protocol error.
  - Beat with start in RECV: resync. Written to buf[0], thread_idx=1, stays RECV, protocol error. Start+end on the same beat follows the abort rule above.
- Write rules: a buffer slot is written only on an accepted beat. Unwritten slots keep their previous packet's data.
- Latency: scatter_valid rises the cycle after the final beat is accepted.
- DELIVER handshake:
  - thread_ack[i] while scatter_valid[i]=1 clears bit i on the next edge.
  - thread_ack[i] while scatter_valid[i]=0 is ignored.
  - Simultaneous acks are all honoured.
  - When the last set bit clears -> IDLE, so ready rises the following cycle.
  - page_rank_scatter is stable throughout DELIVER.
- Reset mid-operation: immediate return to reset values. Any partial packet is discarded.
- thread_idx never exceeds NUM_HW_THREADS-1. No wrap-around occurs because DELIVER is entered first.

Optional Feature:
- Macro: DMP_DESERIAL_ERR_EN.
- Defined: adds ports err (out, 1) and err_code (out, 2).
  - err is sticky, set on any protocol error, cleared only by reset.
  - err_code latches the first error: 1 = missing end, 2 = early end, 3 = start mid-packet.
- Undefined: ports absent. Protocol-error handling (abort/resync/deliver) is identical; errors are silent.

Test Plan:
1. N=8, beats 0..7 with start on beat 0, end on beat 7, data word j of thread i = i*100+j.
   -> scatter_valid=8'hFF one cycle after beat 7; page_rank_scatter[5][3]=503.
   -> Ack threads one per cycle in order 7..0: valid bits clear in that order; busy drops after ack 0; ready=1 next cycle.
2. Stalls: stream_valid low 3 cycles between beats 2 and 3.
   -> Identical buffer to scenario 1; no extra beat written.
   -> stream_ready=0 in DELIVER: a beat offered then is not consumed.
3. Early end: end asserted on beat 4.
   -> IDLE, scatter_valid stays 0.
   -> With ERR_EN: err=1, err_code=2. Next full packet is delivered normally.
4. Resync: start reasserted on beat 3 with data 0xAA, followed by 7 more beats ending with end.
   -> buf[0]=0xAA words; delivery after those 7 beats.
   -> With ERR_EN: err_code=3.
5. Ack edge cases: thread_ack=8'hFF in IDLE -> ignored. In DELIVER, ack 8'h0F then 8'hF0 -> IDLE after the second ack.
6. Reset asserted mid-RECV at beat 5, then released.
   -> All outputs at reset values.
   -> A beat without start is dropped; a beat with start is accepted.
